ddr_upload_reader: RTL and testbench



---
 rtl/cave_ddr_pkg.sv | 26 ++
 rtl/ddr_upload_reader_if.sv | 39 +++
 rtl/upload_line_buffer.sv | 40 ++++
 rtl/ddr_upload_reader.sv | 182 ++++++++++++++++++
 tb/tb_ddr_upload_reader.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cave_ddr_pkg.sv
// Shared DDR types for the cave DDR download/upload paths.
// Contents:
//   ddr_addr_t      32-bit DDR byte address
//   ddr_data_t      64-bit DDR beat
//   DDR_BEAT_BYTES  bytes per 64-bit beat
//   upload_state_t  control states of the upload reader
//   beat_lane()     picks one 16-bit lane out of a beat (lane 0 = bits 15:0)
package cave_ddr_pkg;

    typedef logic [31:0] ddr_addr_t;
    typedef logic [63:0] ddr_data_t;

    localparam int DDR_BEAT_BYTES = 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL,
        SERVE
    } upload_state_t;

    function automatic logic [15:0] beat_lane(input ddr_data_t beat, input logic [1:0] lane);
        return beat[{lane, 4'b0000} +: 16];
    endfunction

endpackage

// File: rtl/ddr_upload_reader_if.sv
// Signal bundle between the upload reader and its environment (hps_io on the
// ioctl side, the DDR arbiter on the Avalon side).
//   ioctl_upload/ioctl_rd/ioctl_addr  read requests from hps_io
//   ioctl_din/ioctl_wait              read data and stall back to hps_io
//   ddr_rd/ddr_addr/ddr_burst_count   Avalon burst read request
//   ddr_wait_req/ddr_valid/ddr_dout   arbiter backpressure and read beats
// Modport master is the reader itself (it masters the DDR burst);
// modport slave is the environment that answers it.
interface ddr_upload_reader_if;
    import cave_ddr_pkg::*;

    logic        ioctl_upload;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [15:0] ioctl_din;
    logic        ioctl_wait;

    logic        ddr_rd;
    ddr_addr_t   ddr_addr;
    logic [7:0]  ddr_burst_count;
    logic        ddr_wait_req;
    logic        ddr_valid;
    ddr_data_t   ddr_dout;

    modport master (
        input  ioctl_upload, ioctl_rd, ioctl_addr,
        output ioctl_din, ioctl_wait,
        output ddr_rd, ddr_addr, ddr_burst_count,
        input  ddr_wait_req, ddr_valid, ddr_dout
    );

    modport slave (
        output ioctl_upload, ioctl_rd, ioctl_addr,
        input  ioctl_din, ioctl_wait,
        input  ddr_rd, ddr_addr, ddr_burst_count,
        output ddr_wait_req, ddr_valid, ddr_dout
    );

endinterface

// File: rtl/upload_line_buffer.sv
// One cached DDR line: BURST_LEN x 64-bit registers, written one beat at a
// time, read as a 16-bit word selected by (beat, lane).
// Ports:
//   clk_sys           clock
//   wr_en/wr_beat     store wr_data into the given beat
//   rd_beat/rd_lane   combinational 16-bit read selection
//   rd_data           selected 16-bit word
// No reset: contents are only ever read after a full line fill.
module upload_line_buffer
    import cave_ddr_pkg::*;
#(
    parameter int BURST_LEN = 4,
    parameter int BEAT_W    = 2
) (
    input  logic              clk_sys,
    input  logic              wr_en,
    input  logic [BEAT_W-1:0] wr_beat,
    input  ddr_data_t         wr_data,
    input  logic [BEAT_W-1:0] rd_beat,
    input  logic [1:0]        rd_lane,
    output logic [15:0]       rd_data
);

    ddr_data_t line_q [BURST_LEN];
    ddr_data_t line_d [BURST_LEN];

    always_comb begin
        line_d = line_q;
        if (wr_en) begin
            line_d[wr_beat] = wr_data;
        end
    end

    always_ff @(posedge clk_sys) begin
        line_q <= line_d;
    end

    assign rd_data = beat_lane(line_q[rd_beat], rd_lane);

endmodule

// File: rtl/ddr_upload_reader.sv
// Serves hps_io 16-bit upload reads from a one-line cache filled by DDR
// burst reads through the arbiter.
// Ports:
//   clk_sys   system clock
//   reset_n   asynchronous active-low reset
//   bus       ddr_upload_reader_if.master (ioctl side + Avalon read side)
// A hit returns ioctl_din one cycle after ioctl_rd without stalling; a miss
// raises ioctl_wait, fetches the whole line, then serves the word.
module ddr_upload_reader
    import cave_ddr_pkg::*;
#(
    parameter ddr_addr_t BASE_ADDR = 32'h0000_0000,
    parameter int        BURST_LEN = 4
) (
    input  logic                       clk_sys,
    input  logic                       reset_n,
    ddr_upload_reader_if.master        bus
);

    localparam int LINE_BYTES = BURST_LEN * DDR_BEAT_BYTES;
    localparam int OFF_W      = $clog2(LINE_BYTES);
    localparam int BEAT_SHIFT = $clog2(DDR_BEAT_BYTES);
    localparam int BEAT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int TAG_W      = 25 - OFF_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    function automatic logic [TAG_W-1:0] tag_of(input logic [24:0] a);
        return TAG_W'(a >> OFF_W);
    endfunction

    function automatic logic [BEAT_W-1:0] beat_of(input logic [24:0] a);
        return BEAT_W'((a >> BEAT_SHIFT) & 25'(BURST_LEN - 1));
    endfunction

    upload_state_t     state_q, state_d;
    logic [24:0]       addr_q, addr_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              tag_valid_q, tag_valid_d;
    logic              upload_prev_q;
    logic [15:0]       ioctl_din_q, ioctl_din_d;
    logic              ioctl_wait_q, ioctl_wait_d;
    logic              ddr_rd_q, ddr_rd_d;
    ddr_addr_t         ddr_addr_q, ddr_addr_d;

    logic              upload_rise;
    logic              hit;
    logic              fill_done;
    logic              wr_en;
    logic [BEAT_W-1:0] wr_beat;
    logic [24:0]       rd_sel_addr;
    logic [15:0]       line_rd_data;

    // A new upload session may follow DDR writes, so the cached line is
    // treated as stale from the very cycle the session starts.
    assign upload_rise = bus.ioctl_upload && !upload_prev_q;
    assign hit         = tag_valid_q && !upload_rise && (tag_q == tag_of(bus.ioctl_addr));

    // SERVE reads the word latched at miss time; IDLE answers hits live.
    assign rd_sel_addr = (state_q == SERVE) ? addr_q : bus.ioctl_addr;

    upload_line_buffer #(
        .BURST_LEN (BURST_LEN),
        .BEAT_W    (BEAT_W)
    ) u_line (
        .clk_sys (clk_sys),
        .wr_en   (wr_en),
        .wr_beat (wr_beat),
        .wr_data (bus.ddr_dout),
        .rd_beat (beat_of(rd_sel_addr)),
        .rd_lane (rd_sel_addr[2:1]),
        .rd_data (line_rd_data)
    );

    // Control FSM: request the line on a miss, collect the burst, then hand
    // the word back. Beats arriving outside REQ-accept/FILL are dropped.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        beat_cnt_d   = beat_cnt_q;
        tag_d        = tag_q;
        tag_valid_d  = tag_valid_q;
        ioctl_din_d  = ioctl_din_q;
        ioctl_wait_d = ioctl_wait_q;
        ddr_rd_d     = ddr_rd_q;
        ddr_addr_d   = ddr_addr_q;
        wr_en        = 1'b0;
        wr_beat      = '0;
        fill_done    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.ioctl_rd && bus.ioctl_upload) begin
                    if (hit) begin
                        ioctl_din_d = line_rd_data;
                    end else begin
                        addr_d       = bus.ioctl_addr;
                        ioctl_wait_d = 1'b1;
                        ddr_rd_d     = 1'b1;
                        ddr_addr_d   = BASE_ADDR + (ddr_addr_t'(tag_of(bus.ioctl_addr)) << OFF_W);
                        state_d      = REQ;
                    end
                end
            end
            REQ: begin
                if (!bus.ddr_wait_req) begin
                    ddr_rd_d   = 1'b0;
                    beat_cnt_d = '0;
                    state_d    = FILL;
                    if (bus.ddr_valid) begin
                        wr_en = 1'b1;
                        if (BURST_LEN == 1) begin
                            fill_done = 1'b1;
                        end else begin
                            beat_cnt_d = BEAT_W'(1);
                        end
                    end
                end
            end
            FILL: begin
                if (bus.ddr_valid) begin
                    wr_en   = 1'b1;
                    wr_beat = beat_cnt_q;
                    if (beat_cnt_q == LAST_BEAT) begin
                        fill_done = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            SERVE: begin
                ioctl_din_d  = line_rd_data;
                ioctl_wait_d = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (fill_done) begin
            tag_valid_d = 1'b1;
            tag_d       = tag_of(addr_q);
            state_d     = SERVE;
        end

        if (upload_rise) begin
            tag_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            beat_cnt_q    <= '0;
            tag_q         <= '0;
            tag_valid_q   <= 1'b0;
            upload_prev_q <= 1'b0;
            ioctl_din_q   <= '0;
            ioctl_wait_q  <= 1'b0;
            ddr_rd_q      <= 1'b0;
            ddr_addr_q    <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            beat_cnt_q    <= beat_cnt_d;
            tag_q         <= tag_d;
            tag_valid_q   <= tag_valid_d;
            upload_prev_q <= bus.ioctl_upload;
            ioctl_din_q   <= ioctl_din_d;
            ioctl_wait_q  <= ioctl_wait_d;
            ddr_rd_q      <= ddr_rd_d;
            ddr_addr_q    <= ddr_addr_d;
        end
    end

    assign bus.ioctl_din       = ioctl_din_q;
    assign bus.ioctl_wait      = ioctl_wait_q;
    assign bus.ddr_rd          = ddr_rd_q;
    assign bus.ddr_addr        = ddr_addr_q;
    assign bus.ddr_burst_count = 8'(BURST_LEN);

endmodule

// File: tb/tb_ddr_upload_reader.sv
// Bench for ddr_upload_reader with BURST_LEN=4, BASE_ADDR=0x0300_0000.
// A small arbiter model answers bursts from a word array; reads are pushed
// into a scoreboard queue with the expected word and stall length, and an
// independent monitor pops and compares when hps_io would sample the data.
module tb_ddr_upload_reader;
    import cave_ddr_pkg::*;

    localparam ddr_addr_t BASE  = 32'h0300_0000;
    localparam int        BURST = 4;

    typedef struct {
        logic [15:0] din;
        int          waits;
    } exp_t;

    logic clk;
    logic reset_n;

    ddr_upload_reader_if bus();

    logic      manual_ddr;
    logic      model_valid;
    ddr_data_t model_dout;
    logic      man_valid;
    ddr_data_t man_dout;

    assign bus.ddr_valid = manual_ddr ? man_valid : model_valid;
    assign bus.ddr_dout  = manual_ddr ? man_dout  : model_dout;

    ddr_data_t mem [0:63];
    exp_t      sb [$];

    int        checks;
    int        errors;
    int        accept_count;
    ddr_addr_t last_addr;
    logic [7:0] last_count;

    ddr_upload_reader #(
        .BASE_ADDR (BASE),
        .BURST_LEN (BURST)
    ) dut (
        .clk_sys (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // One read strobe; when push is set the expected response is queued,
    // then the bench waits (bounded) for the monitor to consume it.
    task automatic applyStimulus(input logic [24:0] addr, input logic [15:0] exp_din,
                                 input int exp_waits, input bit push);
        exp_t e;
        @(negedge clk);
        bus.ioctl_rd   = 1'b1;
        bus.ioctl_addr = addr;
        if (push) begin
            e.din   = exp_din;
            e.waits = exp_waits;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.ioctl_rd = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL response_timeout: addr %h still pending, %0d queued", addr, sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    // Arbiter model: accepts when ddr_rd is seen with no wait request, then
    // returns the four beats on consecutive cycles.
    initial begin
        int base_word;
        model_valid  = 1'b0;
        model_dout   = '0;
        accept_count = 0;
        last_addr    = '0;
        last_count   = '0;
        forever begin
            @(posedge clk);
            if (!manual_ddr && reset_n && bus.ddr_rd && !bus.ddr_wait_req) begin
                accept_count++;
                last_addr  = bus.ddr_addr;
                last_count = bus.ddr_burst_count;
                base_word  = int'((bus.ddr_addr - BASE) >> 3);
                for (int b = 0; b < BURST; b++) begin
                    @(negedge clk);
                    model_valid = 1'b1;
                    model_dout  = mem[base_word + b];
                end
                @(negedge clk);
                model_valid = 1'b0;
            end
        end
    end

    // Monitor: a read accepted on a rising edge is answered once ioctl_wait
    // is low on a falling edge; the number of stalled samples is compared too.
    initial begin
        int   wc;
        bit   aborted;
        bit   done;
        exp_t e;
        forever begin
            @(posedge clk);
            if (reset_n && bus.ioctl_rd && bus.ioctl_upload) begin
                wc      = 0;
                aborted = 1'b0;
                done    = 1'b0;
                while (!done) begin
                    @(negedge clk);
                    if (!reset_n) begin
                        aborted = 1'b1;
                        done    = 1'b1;
                    end else if (!bus.ioctl_wait) begin
                        done = 1'b1;
                    end else begin
                        wc++;
                        if (wc > 40) done = 1'b1;
                    end
                end
                if (!aborted) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_response: din %h with nothing expected", bus.ioctl_din);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("ioctl_din", 64'(bus.ioctl_din), 64'(e.din));
                        checkOutput("wait_cycles", 64'(wc), 64'(e.waits));
                    end
                end
            end
        end
    end

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b1;
        manual_ddr       = 1'b0;
        man_valid        = 1'b0;
        man_dout         = '0;
        bus.ioctl_upload = 1'b0;
        bus.ioctl_rd     = 1'b0;
        bus.ioctl_addr   = '0;
        bus.ddr_wait_req = 1'b0;

        for (int i = 0; i < 64; i++) mem[i] = 64'(i) * 64'h0101_0101_0101_0101;
        mem[0]  = 64'h4444_3333_2222_1111;
        mem[1]  = 64'h8888_7777_6666_5555;
        mem[4]  = 64'hDDDD_CCCC_BBBB_AAAA;
        mem[9]  = 64'h1357_9BDF_2468_ACE0;
        mem[12] = 64'hFEED_FACE_CAFE_BEEF;
        mem[13] = 64'h0BAD_F00D_DEAD_C0DE;

        // Reset values
        #1 reset_n = 1'b0;
        #2;
        checkOutput("rst_ioctl_din", 64'(bus.ioctl_din), 64'h0);
        checkOutput("rst_ioctl_wait", 64'(bus.ioctl_wait), 64'h0);
        checkOutput("rst_ddr_rd", 64'(bus.ddr_rd), 64'h0);
        checkOutput("rst_ddr_addr", 64'(bus.ddr_addr), 64'h0);
        checkOutput("rst_burst_count", 64'(bus.ddr_burst_count), 64'd4);
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        bus.ioctl_upload = 1'b1;
        @(negedge clk);

        $display("[TB] cold read 0x02");
        applyStimulus(25'h000002, 16'h2222, 6, 1'b1);
        checkOutput("cold_accepts", 64'(accept_count), 64'd1);
        checkOutput("cold_ddr_addr", 64'(last_addr), 64'h0300_0000);
        checkOutput("cold_burst_count", 64'(last_count), 64'd4);

        $display("[TB] sequential hits");
        applyStimulus(25'h000004, 16'h3333, 0, 1'b1);
        applyStimulus(25'h000006, 16'h4444, 0, 1'b1);
        applyStimulus(25'h000008, 16'h5555, 0, 1'b1);
        checkOutput("hit_accepts", 64'(accept_count), 64'd1);

        $display("[TB] line cross 0x20");
        applyStimulus(25'h000020, 16'hAAAA, 6, 1'b1);
        checkOutput("cross_accepts", 64'(accept_count), 64'd2);
        checkOutput("cross_ddr_addr", 64'(last_addr), 64'h0300_0020);

        $display("[TB] backpressure read 0x4A");
        begin
            exp_t e;
            @(negedge clk);
            bus.ddr_wait_req = 1'b1;
            bus.ioctl_rd     = 1'b1;
            bus.ioctl_addr   = 25'h00004A;
            e.din   = 16'h2468;
            e.waits = 11;
            sb.push_back(e);
            @(negedge clk);
            bus.ioctl_rd = 1'b0;
            for (int i = 0; i < 5; i++) begin
                checkOutput("bp_ddr_rd", 64'(bus.ddr_rd), 64'h1);
                checkOutput("bp_ddr_addr", 64'(bus.ddr_addr), 64'h0300_0040);
                @(negedge clk);
            end
            bus.ddr_wait_req = 1'b0;
            for (int i = 0; i < 80; i++) begin
                if (sb.size() == 0) break;
                @(negedge clk);
            end
            if (sb.size() != 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL bp_timeout: %0d responses pending", sb.size());
                sb.delete();
            end
            @(negedge clk);
        end
        checkOutput("bp_accepts", 64'(accept_count), 64'd3);
        checkOutput("bp_ddr_addr_acc", 64'(last_addr), 64'h0300_0040);

        $display("[TB] session restart");
        @(negedge clk);
        bus.ioctl_upload = 1'b0;
        applyStimulus(25'h000002, 16'h0000, 0, 1'b0);
        checkOutput("ignored_din", 64'(bus.ioctl_din), 64'h2468);
        checkOutput("ignored_wait", 64'(bus.ioctl_wait), 64'h0);
        checkOutput("ignored_accepts", 64'(accept_count), 64'd3);
        mem[0] = 64'h4444_3333_5A5A_1111;
        @(negedge clk);
        bus.ioctl_upload = 1'b1;
        @(negedge clk);
        applyStimulus(25'h000002, 16'h5A5A, 6, 1'b1);
        checkOutput("restart_accepts", 64'(accept_count), 64'd4);
        applyStimulus(25'h000006, 16'h4444, 0, 1'b1);

        $display("[TB] reset during fill");
        manual_ddr = 1'b1;
        @(negedge clk);
        bus.ioctl_rd   = 1'b1;
        bus.ioctl_addr = 25'h000060;
        @(negedge clk);
        bus.ioctl_rd = 1'b0;
        checkOutput("rf_ddr_rd", 64'(bus.ddr_rd), 64'h1);
        checkOutput("rf_ddr_addr", 64'(bus.ddr_addr), 64'h0300_0060);
        checkOutput("rf_wait", 64'(bus.ioctl_wait), 64'h1);
        man_valid = 1'b1;
        man_dout  = mem[12];
        @(negedge clk);
        man_dout  = mem[13];
        @(negedge clk);
        man_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rf_rst_din", 64'(bus.ioctl_din), 64'h0);
        checkOutput("rf_rst_wait", 64'(bus.ioctl_wait), 64'h0);
        checkOutput("rf_rst_ddr_rd", 64'(bus.ddr_rd), 64'h0);
        checkOutput("rf_rst_ddr_addr", 64'(bus.ddr_addr), 64'h0);
        checkOutput("rf_rst_count", 64'(bus.ddr_burst_count), 64'd4);
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        man_valid = 1'b1;
        man_dout  = 64'h9999_9999_9999_9999;
        @(negedge clk);
        @(negedge clk);
        man_valid = 1'b0;
        checkOutput("stray_wait", 64'(bus.ioctl_wait), 64'h0);
        checkOutput("stray_ddr_rd", 64'(bus.ddr_rd), 64'h0);
        checkOutput("stray_din", 64'(bus.ioctl_din), 64'h0);
        manual_ddr = 1'b0;
        @(negedge clk);
        applyStimulus(25'h000000, 16'h1111, 6, 1'b1);
        checkOutput("post_rst_accepts", 64'(accept_count), 64'd5);
        checkOutput("post_rst_ddr_addr", 64'(last_addr), 64'h0300_0000);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
